// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//
// Definitions shared by the bit-serial add/subtract controller:
//   - state_e : controller FSM encoding (IDLE / RUN / DONE)
//   - clog2() : ceiling log2, used to size the bit counter
//
// Build option: SERIAL_ADD_OVF_EN (adds a signed-overflow output). Nothing
// in this package depends on it.
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2. Returns 0 for values <= 1, so callers that need a
    // non-empty vector must clamp the result to at least 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//
// Groups the operand request channel and the result channel of the
// bit-serial adder.
//
//   Request channel (master -> slave, in_ready back)
//     in_valid, op_a[WIDTH], op_b[WIDTH], op_cin, op_sub  / in_ready
//   Result channel (slave -> master, out_ready back)
//     out_valid, sum[WIDTH], cout, ovf (only with SERIAL_ADD_OVF_EN) / out_ready
//
// Modports:
//   master : the requester / result consumer
//   slave  : serial_add_ctrl
//
// Build option: SERIAL_ADD_OVF_EN adds the ovf signal to both modports.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/serial_add_dp.sv
// ---------------------------------------------------------------------------
// serial_add_dp
//
// Datapath of the bit-serial adder: two operand shift registers, the result
// shift register, the recirculating carry flop and one gate-level full-adder
// cell. One bit pair is consumed per shift, LSB first; each sum bit enters
// the result register at the MSB, so after WIDTH shifts the result holds
// the complete word.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   load          capture operands (B inverted for subtract) and carry-in
//   shift         process one bit pair
//   last          (SERIAL_ADD_OVF_EN only) current shift handles the MSB
//   op_a, op_b    operands, sampled only while load is high
//   op_cin        carry-in for add
//   op_sub        1: subtract (B inverted, carry-in forced to 1)
//   sum           result register
//   cout          carry flop; holds carry-out of the MSB once finished
//   ovf           (SERIAL_ADD_OVF_EN only) signed overflow of the last op
//
// Build option: SERIAL_ADD_OVF_EN enables the last/ovf ports and the
// overflow capture logic.
// ---------------------------------------------------------------------------
module serial_add_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
`ifdef SERIAL_ADD_OVF_EN
    input  logic             last,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // -----------------------------------------------------------------
    // Structural 1-bit full-adder cell
    // -----------------------------------------------------------------
    logic fa_p;
    logic fa_g;
    logic fa_pc;
    logic s_bit;
    logic c_bit;

    xor u_fa_x0 (fa_p,  a_sh_q[0], b_sh_q[0]);
    xor u_fa_x1 (s_bit, fa_p,      carry_q);
    and u_fa_a0 (fa_g,  a_sh_q[0], b_sh_q[0]);
    and u_fa_a1 (fa_pc, fa_p,      carry_q);
    or  u_fa_o0 (c_bit, fa_g,      fa_pc);

    // Result register shifted right with the new sum bit entering at the
    // MSB. Built per bit so it also elaborates cleanly for WIDTH == 1.
    logic [WIDTH-1:0] res_shift;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res_shift
        if (gi == WIDTH - 1) begin : g_msb
            assign res_shift[gi] = s_bit;
        end else begin : g_lower
            assign res_shift[gi] = res_q[gi+1];
        end
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (load) begin
            a_sh_d  = op_a;
            b_sh_d  = op_sub ? ~op_b : op_b;
            // Subtract is A + ~B + 1, so the carry-in is forced high.
            carry_d = op_sub | op_cin;
            res_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else if (shift) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = res_shift;
            carry_d = c_bit;
`ifdef SERIAL_ADD_OVF_EN
            // While the MSB pair is in the cell, carry_q is the carry into
            // the MSB and c_bit the carry out of it.
            if (last) begin
                ovf_d = carry_q ^ c_bit;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = res_q;
    assign cout = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add/subtract controller. Accepts a WIDTH-bit operand pair,
// pushes it one bit per cycle through a single full-adder cell (in
// serial_add_dp) and returns the result on a valid/ready channel.
//
// Ports
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   serial_add_ctrl_if.slave:
//           in_valid/in_ready, op_a, op_b, op_cin, op_sub  (request)
//           out_valid/out_ready, sum, cout[, ovf]          (result)
//
// Timing: a request accepted at edge T is processed on edges T+1..T+WIDTH,
// out_valid rises after edge T+WIDTH. A result being accepted and a new
// request can share one cycle, giving one operation per WIDTH+1 cycles.
//
// Build option: SERIAL_ADD_OVF_EN adds the signed-overflow output bus.ovf.
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);

    // Counter must be at least one bit wide even for WIDTH == 1.
    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            in_ready;
    logic            accept;
    logic            load;
    logic            shift;
    logic            last;

    // rst is folded in so no request is signalled while reset is held.
    assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        // Back-to-back: the new operands overwrite the
                        // result in the same edge it is handed over.
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);

    serial_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
`ifdef SERIAL_ADD_OVF_EN
        .last   (last),
`endif
        .op_a   (bus.op_a),
        .op_b   (bus.op_b),
        .op_cin (bus.op_cin),
        .op_sub (bus.op_sub),
        .sum    (bus.sum),
        .cout   (bus.cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf    (bus.ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    // Without the overflow output the MSB marker has no consumer.
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl with WIDTH = 8. Requests are
// driven through the interface; the expected result of every accepted
// request is computed by a word-level model and queued, and a monitor pops
// and compares whenever the DUT hands a result over.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   n_results;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        bb     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        // Signed overflow: operands of equal sign giving a result of the other sign.
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Result monitor: one line per handed-over result.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", bus.out_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_results++;
                $display("result %0d: sum=0x%02h cout=%0d (exp sum=0x%02h cout=%0d)",
                         n_results, bus.sum, bus.cout, e.sum, e.cout);
                check_eq("sum", bus.sum, e.sum);
                check_eq("cout", bus.cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                check_eq("ovf", bus.ovf, e.ovf);
`endif
            end
        end
    end

    // Drives a request from the current time until it is accepted. The
    // caller is just past a rising edge. Operands are scrambled afterwards
    // to show that only the accepted values matter.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit got;
        got         = 1'b0;
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.op_sub   = sub;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        check_eq("accept", {31'd0, got}, 32'd1);
        if (got) begin
            sb.push_back(model(a, b, cin, sub));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.op_a     = W'($urandom);
        bus.op_b     = W'($urandom);
        bus.op_cin   = 1'($urandom);
        bus.op_sub   = 1'($urandom);
    endtask

    // Counts rising edges from acceptance until out_valid is seen; leaves
    // the bench at the falling edge where it was seen.
    task automatic wait_latency(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int lat;
        send(a, b, cin, sub);
        wait_latency(lat);
        check_eq("latency", lat, W);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   lat;
        int   seen;
        exp_t held;

        n_checks     = 0;
        n_fail       = 0;
        n_results    = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.op_cin   = 1'b0;
        bus.op_sub   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_sum", bus.sum, 8'h00);
        check_eq("rst_cout", bus.cout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed add/subtract cases
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h10, 8'h01, 1'b0, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b1);
        run_op(8'h33, 8'h44, 1'b1, 1'b1);   // subtract ignores op_cin

        // Result held under back-pressure, requests ignored, then
        // back-to-back hand-over and new request.
        bus.out_ready = 1'b0;
        held = model(8'hA5, 8'h5B, 1'b1, 1'b0);
        send(8'hA5, 8'h5B, 1'b1, 1'b0);
        wait_latency(lat);
        check_eq("bp_latency", lat, W);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.op_a     = W'($urandom);
            bus.op_b     = W'($urandom);
            @(negedge clk);
            check_eq("bp_out_valid", bus.out_valid, 1'b1);
            check_eq("bp_sum_hold", bus.sum, held.sum);
            check_eq("bp_cout_hold", bus.cout, held.cout);
            check_eq("bp_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(8'h12, 8'h34, 1'b0, 1'b0);
        wait_latency(lat);
        check_eq("b2b_latency", lat, W);
        @(posedge clk);
        #1;

        // Reset in the middle of a run abandons the operation.
        send(8'hC3, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_in_ready", bus.in_ready, 1'b0);
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        check_eq("midrst_sum", bus.sum, 8'h00);
        check_eq("midrst_cout", bus.cout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("postrst_in_ready", bus.in_ready, 1'b1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_eq("postrst_no_result", seen, 0);
        @(posedge clk);
        #1;

`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1);
`endif

        // Random operations
        for (int i = 0; i < 10; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
